// File: rtl/line_buffer_ntap.sv
// N-tap video line buffer: cascaded single-port line RAMs deliver the same column
// from the previous NUM_TAPS lines, with top-border fill until enough lines exist.
module line_buffer_ntap #(
  parameter int DATA_W      = 8,
  parameter int LINE_W      = 1936,
  parameter int NUM_TAPS    = 2,
  parameter int BORDER_MODE = 1,
  parameter int ADDR_W      = 11
) (
  input  logic                         clock,
  input  logic                         rst,
  input  logic                         clken,
  input  logic                         per_frame_vsync,
  input  logic                         per_frame_href,
  input  logic [DATA_W-1:0]            shiftin,
  output logic                         post_clken,
  output logic                         post_href,
  output logic [DATA_W-1:0]            taps0,
  output logic [NUM_TAPS*DATA_W-1:0]   taps,
  output logic [NUM_TAPS-1:0]          taps_valid,
  output logic [2:0]                   line_cnt,
  output logic                         overflow
);

  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(LINE_W - 1);

  logic [DATA_W-1:0] mem  [NUM_TAPS][LINE_W];
  logic [DATA_W-1:0] rd_q [NUM_TAPS];

  logic              href_d, vsync_d;
  logic              href_rise, href_fall, vsync_rise, line_start;
  logic [ADDR_W-1:0] addr, col;
  logic              col_full, full_eff;
  logic              seen_pix;

  assign href_rise  = per_frame_href & ~href_d;
  assign href_fall  = ~per_frame_href & href_d;
  assign vsync_rise = per_frame_vsync & ~vsync_d;
  assign line_start = href_rise | vsync_rise;

  // A line start takes effect in the same cycle, so a coincident pixel lands in column 0.
  assign col      = line_start ? '0 : addr;
  assign full_eff = line_start ? 1'b0 : col_full;

  always_ff @(posedge clock) begin
    if (rst) begin
      href_d   <= 1'b0;
      vsync_d  <= 1'b0;
      addr     <= '0;
      col_full <= 1'b0;
      overflow <= 1'b0;
      seen_pix <= 1'b0;
      line_cnt <= '0;
    end else begin
      href_d  <= per_frame_href;
      vsync_d <= per_frame_vsync;

      if (clken) begin
        if (col == LAST_COL) begin
          addr     <= LAST_COL;
          col_full <= 1'b1;
        end else begin
          addr     <= col + 1'b1;
          col_full <= 1'b0;
        end
      end else if (line_start) begin
        addr     <= '0;
        col_full <= 1'b0;
      end

      // The last column may be written once; any further write in that line overflows.
      if (vsync_rise)
        overflow <= 1'b0;
      else if (clken && col == LAST_COL && full_eff)
        overflow <= 1'b1;

      if (line_start)
        seen_pix <= clken;
      else if (href_fall)
        seen_pix <= 1'b0;
      else if (clken)
        seen_pix <= 1'b1;

      if (vsync_rise)
        line_cnt <= '0;
      else if (href_fall && seen_pix && line_cnt < 3'(NUM_TAPS))
        line_cnt <= line_cnt + 3'd1;
    end
  end

  // Read-before-write: each RAM passes its old content down the cascade.
  always_ff @(posedge clock) begin
    if (clken && !rst) begin
      mem[0][col] <= shiftin;
      for (int unsigned k = 1; k < NUM_TAPS; k++)
        mem[k][col] <= mem[k-1][col];
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      post_clken <= 1'b0;
      post_href  <= 1'b0;
      taps0      <= '0;
      taps_valid <= '0;
      for (int unsigned k = 0; k < NUM_TAPS; k++)
        rd_q[k] <= '0;
    end else begin
      post_clken <= clken;
      post_href  <= per_frame_href;
      if (clken) begin
        taps0 <= shiftin;
        for (int unsigned k = 0; k < NUM_TAPS; k++) begin
          rd_q[k]       <= mem[k][col];
          taps_valid[k] <= (line_cnt > 3'(k));
        end
      end
    end
  end

  // Invalid rows are zeroed or replaced by the nearest newer row.
  always_comb begin
    logic [DATA_W-1:0] slice;
    logic [DATA_W-1:0] newer;
    taps  = '0;
    slice = '0;
    newer = taps0;
    for (int unsigned k = 0; k < NUM_TAPS; k++) begin
      if (taps_valid[k])
        slice = rd_q[k];
      else if (BORDER_MODE == 1)
        slice = newer;
      else
        slice = '0;
      taps[k*DATA_W +: DATA_W] = slice;
      newer = slice;
    end
  end

endmodule

// File: tb/tb_line_buffer_ntap.sv
// Directed bench for line_buffer_ntap: two instances (zero fill and replicate fill)
// driven by the same stimulus, LINE_W=4, NUM_TAPS=2.
module tb_line_buffer_ntap;

  logic        clock = 1'b0;
  logic        rst, clken, vsync, href;
  logic [7:0]  shiftin;

  logic        d0_pc, d0_ph, d0_ovf, d1_pc, d1_ph, d1_ovf;
  logic [7:0]  d0_t0, d1_t0;
  logic [15:0] d0_taps, d1_taps;
  logic [1:0]  d0_v, d1_v;
  logic [2:0]  d0_lc, d1_lc;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  line_buffer_ntap #(.DATA_W(8), .LINE_W(4), .NUM_TAPS(2), .BORDER_MODE(0), .ADDR_W(2)) u_dut0 (
    .clock(clock), .rst(rst), .clken(clken), .per_frame_vsync(vsync),
    .per_frame_href(href), .shiftin(shiftin), .post_clken(d0_pc), .post_href(d0_ph),
    .taps0(d0_t0), .taps(d0_taps), .taps_valid(d0_v), .line_cnt(d0_lc), .overflow(d0_ovf));

  line_buffer_ntap #(.DATA_W(8), .LINE_W(4), .NUM_TAPS(2), .BORDER_MODE(1), .ADDR_W(2)) u_dut1 (
    .clock(clock), .rst(rst), .clken(clken), .per_frame_vsync(vsync),
    .per_frame_href(href), .shiftin(shiftin), .post_clken(d1_pc), .post_href(d1_ph),
    .taps0(d1_t0), .taps(d1_taps), .taps_valid(d1_v), .line_cnt(d1_lc), .overflow(d1_ovf));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One pixel; a*: zero-fill slices, b*: replicate-fill slices, v: taps_valid
  task automatic pix(input string tag, input logic [7:0] p,
                     input logic [7:0] a0, input logic [7:0] a1,
                     input logic [7:0] b0, input logic [7:0] b1, input logic [1:0] v);
    clken   = 1'b1;
    shiftin = p;
    step();
    clken = 1'b0;
    chk({tag, ".taps0"},  32'(d0_t0), 32'(p));
    chk({tag, ".taps0b"}, 32'(d1_t0), 32'(p));
    chk({tag, ".pclk"},   32'(d0_pc), 32'd1);
    chk({tag, ".taps_z"}, 32'(d0_taps), 32'({a1, a0}));
    chk({tag, ".taps_r"}, 32'(d1_taps), 32'({b1, b0}));
    chk({tag, ".valid"},  32'(d0_v), 32'(v));
    chk({tag, ".validb"}, 32'(d1_v), 32'(v));
  endtask

  task automatic end_line(input string tag, input logic [2:0] lc);
    href  = 1'b0;
    clken = 1'b0;
    step();
    chk({tag, ".line_cnt"},  32'(d0_lc), 32'(lc));
    chk({tag, ".line_cntb"}, 32'(d1_lc), 32'(lc));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".pclk"},  32'({d0_pc, d1_pc}), 32'd0);
    chk({tag, ".phref"}, 32'({d0_ph, d1_ph}), 32'd0);
    chk({tag, ".taps0"}, 32'({d0_t0, d1_t0}), 32'd0);
    chk({tag, ".taps"},  32'({d0_taps, d1_taps}), 32'd0);
    chk({tag, ".valid"}, 32'({d0_v, d1_v}), 32'd0);
    chk({tag, ".lcnt"},  32'({d0_lc, d1_lc}), 32'd0);
    chk({tag, ".ovf"},   32'({d0_ovf, d1_ovf}), 32'd0);
  endtask

  initial begin
    // reset with active inputs: nothing may leak through
    rst = 1'b1; clken = 1'b1; href = 1'b1; vsync = 1'b0; shiftin = 8'hAA;
    step(); step();
    chk_reset("rst");
    rst = 1'b0; clken = 1'b0; href = 1'b0; shiftin = 8'h00;
    step();
    vsync = 1'b1; step(); vsync = 1'b0; step();

    // line 1: href rise coincides with first pixel
    href = 1'b1;
    pix("l1c0", 8'd10, 8'd0, 8'd0, 8'd10, 8'd10, 2'b00);
    chk("l1.phref", 32'(d0_ph), 32'd1);
    pix("l1c1", 8'd11, 8'd0, 8'd0, 8'd11, 8'd11, 2'b00);
    pix("l1c2", 8'd12, 8'd0, 8'd0, 8'd12, 8'd12, 2'b00);
    pix("l1c3", 8'd13, 8'd0, 8'd0, 8'd13, 8'd13, 2'b00);
    end_line("l1", 3'd1);
    step();
    chk("idle.hold_t0", 32'(d0_t0), 32'd13);
    chk("idle.pclk",    32'(d0_pc), 32'd0);

    // line 2: href rises one idle cycle before the first pixel
    href = 1'b1; step();
    pix("l2c0", 8'd20, 8'd10, 8'd0, 8'd10, 8'd10, 2'b01);
    pix("l2c1", 8'd21, 8'd11, 8'd0, 8'd11, 8'd11, 2'b01);
    pix("l2c2", 8'd22, 8'd12, 8'd0, 8'd12, 8'd12, 2'b01);
    pix("l2c3", 8'd23, 8'd13, 8'd0, 8'd13, 8'd13, 2'b01);
    end_line("l2", 3'd2);

    // line 3: one pixel every third cycle
    href = 1'b1;
    pix("l3c0", 8'd30, 8'd20, 8'd10, 8'd20, 8'd10, 2'b11);
    step(); step();
    chk("l3.gap_t0",   32'(d0_t0), 32'd30);
    chk("l3.gap_taps", 32'(d0_taps), 32'({8'd10, 8'd20}));
    pix("l3c1", 8'd31, 8'd21, 8'd11, 8'd21, 8'd11, 2'b11);
    step(); step();
    pix("l3c2", 8'd32, 8'd22, 8'd12, 8'd22, 8'd12, 2'b11);
    step(); step();
    pix("l3c3", 8'd33, 8'd23, 8'd13, 8'd23, 8'd13, 2'b11);
    end_line("l3", 3'd2);

    // line 4: gap-free, line count saturated
    href = 1'b1;
    pix("l4c0", 8'd40, 8'd30, 8'd20, 8'd30, 8'd20, 2'b11);
    pix("l4c1", 8'd41, 8'd31, 8'd21, 8'd31, 8'd21, 2'b11);
    pix("l4c2", 8'd42, 8'd32, 8'd22, 8'd32, 8'd22, 2'b11);
    pix("l4c3", 8'd43, 8'd33, 8'd23, 8'd33, 8'd23, 2'b11);
    end_line("l4", 3'd2);

    // line 5: six pixels into a four-pixel line
    href = 1'b1;
    pix("l5c0", 8'd50, 8'd40, 8'd30, 8'd40, 8'd30, 2'b11);
    pix("l5c1", 8'd51, 8'd41, 8'd31, 8'd41, 8'd31, 2'b11);
    pix("l5c2", 8'd52, 8'd42, 8'd32, 8'd42, 8'd32, 2'b11);
    pix("l5c3", 8'd53, 8'd43, 8'd33, 8'd43, 8'd33, 2'b11);
    chk("l5.ovf_at4", 32'(d0_ovf), 32'd0);
    pix("l5c4", 8'd54, 8'd53, 8'd43, 8'd53, 8'd43, 2'b11);
    chk("l5.ovf_at5", 32'({d0_ovf, d1_ovf}), 32'b11);
    pix("l5c5", 8'd55, 8'd54, 8'd53, 8'd54, 8'd53, 2'b11);
    end_line("l5", 3'd2);
    chk("l5.ovf_sticky", 32'(d0_ovf), 32'd1);

    vsync = 1'b1; step();
    chk("vs.ovf_clr", 32'({d0_ovf, d1_ovf}), 32'd0);
    chk("vs.lcnt",    32'({d0_lc, d1_lc}), 32'd0);
    vsync = 1'b0; step();

    // new frame: border fill again
    href = 1'b1;
    pix("f2l1c0", 8'd60, 8'd0, 8'd0, 8'd60, 8'd60, 2'b00);
    pix("f2l1c1", 8'd61, 8'd0, 8'd0, 8'd61, 8'd61, 2'b00);
    pix("f2l1c2", 8'd62, 8'd0, 8'd0, 8'd62, 8'd62, 2'b00);
    pix("f2l1c3", 8'd63, 8'd0, 8'd0, 8'd63, 8'd63, 2'b00);
    end_line("f2l1", 3'd1);
    href = 1'b1;
    pix("f2l2c0", 8'd70, 8'd60, 8'd0, 8'd60, 8'd60, 2'b01);
    pix("f2l2c1", 8'd71, 8'd61, 8'd0, 8'd61, 8'd61, 2'b01);
    pix("f2l2c2", 8'd72, 8'd62, 8'd0, 8'd62, 8'd62, 2'b01);
    pix("f2l2c3", 8'd73, 8'd63, 8'd0, 8'd63, 8'd63, 2'b01);
    end_line("f2l2", 3'd2);

    // reset in the middle of the third line
    href = 1'b1;
    pix("f2l3c0", 8'd80, 8'd70, 8'd60, 8'd70, 8'd60, 2'b11);
    pix("f2l3c1", 8'd81, 8'd71, 8'd61, 8'd71, 8'd61, 2'b11);
    rst = 1'b1; href = 1'b0; clken = 1'b1; shiftin = 8'd99;
    step();
    chk_reset("mid_rst");
    rst = 1'b0; clken = 1'b0;
    step();
    href = 1'b1;
    pix("pr_c0", 8'd90, 8'd0, 8'd0, 8'd90, 8'd90, 2'b00);
    pix("pr_c1", 8'd91, 8'd0, 8'd0, 8'd91, 8'd91, 2'b00);
    pix("pr_c2", 8'd92, 8'd0, 8'd0, 8'd92, 8'd92, 2'b00);
    pix("pr_c3", 8'd93, 8'd0, 8'd0, 8'd93, 8'd93, 2'b00);
    end_line("pr", 3'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_buffer_ntap.md
LINE_BUFFER_NTAP -- requirements
Module: line_buffer_ntap

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, pixel width in bits.
REQ-002 SHALL provide parameter LINE_W, default 1936, maximum pixels per line (RAM depth).
REQ-003 SHALL provide parameter NUM_TAPS, default 2, number of previous lines delivered (kernel rows minus 1), legal 1..4.
REQ-004 SHALL provide parameter BORDER_MODE, default 1, top-border fill: 0 = zero, 1 = replicate.
REQ-005 SHALL provide parameter ADDR_W, default 11, column address width, with 2^ADDR_W >= LINE_W.
REQ-006 clock  input  1  single clock; all logic rising-edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 clken  input  1  one pixel valid on shiftin this cycle.
REQ-009 per_frame_vsync  input  1  frame sync; a rising edge starts a new frame.
REQ-010 per_frame_href  input  1  line valid; a rising edge starts a new line.
REQ-011 shiftin  input  DATA_W  current-line pixel.
REQ-012 post_clken  output  1  clken delayed 1 cycle.
REQ-013 post_href  output  1  per_frame_href delayed 1 cycle.
REQ-014 taps0  output  DATA_W  shiftin delayed 1 cycle (current line, aligned with the other taps).
REQ-015 taps  output  NUM_TAPS*DATA_W  slice k = pixel at the same column k+1 lines earlier; slice 0 at LSBs.
REQ-016 taps_valid  output  NUM_TAPS  bit k = 1 when slice k holds real data from this frame.
REQ-017 line_cnt  output  3  completed lines this frame, saturating at NUM_TAPS.
REQ-018 overflow  output  1  sticky flag: a line exceeded LINE_W pixels.

Function
REQ-019 Column address SHALL reset to 0 on an href rising edge or a vsync rising edge, and increment by 1 on each clken.
REQ-020 If clken coincides with an href rising edge, the pixel SHALL be written at column 0 and the address SHALL become 1.
REQ-021 At column LINE_W-1, a further clken SHALL hold the address at LINE_W-1, overwrite that column, and set overflow.
REQ-022 Storage SHALL be NUM_TAPS cascaded line RAMs (depth LINE_W, width DATA_W) using read-before-write at the same column; RAM k+1 SHALL be written with the read data of RAM k.
REQ-023 Latency from shiftin/clken to taps0, taps, taps_valid and post_clken SHALL be exactly 1 cycle, with all outputs column-aligned.
REQ-024 line_cnt SHALL increment on an href falling edge only if at least one clken occurred during that line, and SHALL saturate at NUM_TAPS.
REQ-025 taps_valid[k] SHALL equal (line_cnt > k), sampled in the same cycle as the RAM read.
REQ-026 With BORDER_MODE=0, an invalid slice k SHALL output 0.
REQ-027 With BORDER_MODE=1, an invalid slice k SHALL output the nearest valid newer row: slice k-1, or taps0 for k=0.
REQ-028 A vsync rising edge SHALL clear line_cnt and overflow and reset the address; RAM contents SHALL NOT be cleared.
REQ-029 Edge detection of href and vsync SHALL use registered previous values, which reset to 0.
REQ-030 RAM writes SHALL occur only in cycles with clken=1; taps SHALL hold their last value while clken=0.

Reset
REQ-031 While rst=1: post_clken=0, post_href=0, taps0=0, taps=0, taps_valid=0, line_cnt=0, overflow=0, column address=0, edge registers=0; no RAM write.
REQ-032 rst asserted mid-line SHALL abort the line; the first href rising edge after rst release SHALL start column 0 with line_cnt=0.

Verification
REQ-033 LINE_W=4, NUM_TAPS=2, BORDER_MODE=0: lines 10..13, 20..23, 30..33 -> during line 3, taps0=30,31,..; slice0=20,21,..; slice1=10,11,..; taps_valid=2'b11, each 1 cycle after clken.
REQ-034 BORDER_MODE=1, first line 5,6,7,8 -> slice0=slice1=taps0; line 2 -> slice1 equals slice0 (line 1 data), taps_valid=2'b01.
REQ-035 LINE_W=4, feed 6 pixels in one line -> overflow=1 after the 5th clken, address holds at 3; next vsync rising edge clears overflow.
REQ-036 clken gaps (1 of 3 cycles) plus href rising edge coinciding with the first clken -> column alignment of taps is identical to the gap-free run.
REQ-037 rst pulse mid-frame after 2 lines -> all outputs 0 during rst, then line_cnt=0 and taps_valid=0 on the next line.
REQ-038 vsync rising edge after 3 lines -> line_cnt=0, taps_valid=0 on the first line of the new frame; border fill active.
